// File: rtl/rrarbiter_pkg.sv
// Shared definitions for the three-way round-robin printer arbiter.
// Grant encodings double as the FSM state encodings.
package rrarbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BOSS = 2'b01,
        ST_ENG  = 2'b10,
        ST_BOY  = 2'b11
    } state_t;

    // Rotation successor; IDLE maps to BOSS so a search from it is well defined.
    function automatic state_t succ(input state_t s);
        case (s)
            ST_BOSS: succ = ST_ENG;
            ST_ENG:  succ = ST_BOY;
            ST_BOY:  succ = ST_BOSS;
            default: succ = ST_BOSS;
        endcase
    endfunction

    // Request bit belonging to a requester state; req = {boy, eng, boss}.
    function automatic logic req_of(input state_t s, input logic [2:0] req);
        case (s)
            ST_BOSS: req_of = req[0];
            ST_ENG:  req_of = req[1];
            ST_BOY:  req_of = req[2];
            default: req_of = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rrarbiter.sv
// Non-preemptive round-robin arbiter granting one printer to BOSS/ENG/BOY.
// The state register is the grant itself, so printer is a registered output.
module rrarbiter
    import rrarbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rboss,
    input  logic       reng,
    input  logic       rboy,
    output logic [1:0] printer
);

    state_t     state_q, state_d;
    state_t     last_q,  last_d;
    state_t     base, cand1, cand2, cand3;
    logic [2:0] req;
    logic       hold;

    assign req = {rboy, reng, rboss};

    always_comb begin
        hold  = (state_q != ST_IDLE) && req_of(state_q, req);
        // Search starts after the owner, or after the previous owner when idle.
        base  = (state_q == ST_IDLE) ? last_q : state_q;
        cand1 = succ(base);
        cand2 = succ(cand1);
        cand3 = succ(cand2);

        state_d = ST_IDLE;
        if (hold)
            state_d = state_q;
        else if (req_of(cand1, req))
            state_d = cand1;
        else if (req_of(cand2, req))
            state_d = cand2;
        else if (req_of(cand3, req))
            state_d = cand3;

        last_d = (state_d != ST_IDLE) ? state_d : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= ST_BOY;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign printer = state_q;

endmodule

// File: tb/tb_rrarbiter.sv
// Directed and soak checks for the round-robin printer arbiter.
module tb_rrarbiter;

    logic       clk;
    logic       rst;
    logic       rboss;
    logic       reng;
    logic       rboy;
    logic [1:0] printer;

    int n_cmp;
    int n_fail;

    // Independent reference model, integer encoded: 0 idle, 1 boss, 2 eng, 3 boy.
    int         m_state;
    int         m_last;
    int         m_next;
    int         waitc [3];
    logic [1:0] prev_printer;
    logic [2:0] rv;

    rrarbiter dut (
        .clk     (clk),
        .rst     (rst),
        .rboss   (rboss),
        .reng    (reng),
        .rboy    (rboy),
        .printer (printer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: printer=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic b, input logic e, input logic y);
        rboss = b;
        reng  = e;
        rboy  = y;
    endtask

    function automatic int model_next(input int st, input int last, input logic [2:0] r);
        int base;
        int cand;
        if (st != 0 && r[st-1]) return st;
        base = (st != 0) ? st : last;
        for (int k = 1; k <= 3; k++) begin
            cand = (base - 1 + k) % 3 + 1;
            if (r[cand-1]) return cand;
        end
        return 0;
    endfunction

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Reset with every request high
        rst = 1'b1;
        set_req(1'b1, 1'b1, 1'b1);
        #12;
        check("reset_idle", printer, 2'b00);
        $display("reset held, all req=1: printer=%b", printer);
        rst = 1'b0;
        tick; check("first_grant_boss", printer, 2'b01);
        $display("release reset: printer=%b", printer);
        tick; check("boss_holds", printer, 2'b01);

        // Rotation: each owner drops for one cycle
        set_req(1'b0, 1'b1, 1'b1); tick; check("rot_eng", printer, 2'b10);
        $display("boss drops: printer=%b", printer);
        set_req(1'b1, 1'b0, 1'b1); tick; check("rot_boy", printer, 2'b11);
        $display("eng drops: printer=%b", printer);
        set_req(1'b1, 1'b1, 1'b0); tick; check("rot_boss", printer, 2'b01);
        $display("boy drops: printer=%b", printer);

        // Asynchronous reset mid-grant
        set_req(1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        #2;
        check("async_reset", printer, 2'b00);
        $display("async reset mid-grant: printer=%b", printer);
        set_req(1'b0, 1'b0, 1'b0);
        tick;
        rst = 1'b0;

        // Single requester ENG
        set_req(1'b0, 1'b1, 1'b0); tick; check("single_eng", printer, 2'b10);
        $display("reng alone: printer=%b", printer);
        tick; check("single_eng_hold1", printer, 2'b10);
        tick; check("single_eng_hold2", printer, 2'b10);
        set_req(1'b0, 1'b0, 1'b0); tick; check("single_eng_release", printer, 2'b00);
        $display("reng released: printer=%b", printer);

        // Idle priority: last owner ENG, so BOY beats BOSS
        tick;
        set_req(1'b1, 1'b0, 1'b1); tick; check("idle_prio_boy", printer, 2'b11);
        $display("idle, boss+boy: printer=%b", printer);

        // Non-preemption: BOY keeps the grant while rboss waits
        tick; check("nonpreempt_1", printer, 2'b11);
        tick; check("nonpreempt_2", printer, 2'b11);
        set_req(1'b1, 1'b0, 1'b0); tick; check("nonpreempt_handoff", printer, 2'b01);
        $display("boy releases: printer=%b", printer);
        set_req(1'b0, 1'b0, 1'b0); tick; check("back_to_idle", printer, 2'b00);
        $display("all released: printer=%b", printer);

        // Random soak against the model with a fairness bound
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_state = 0;
        m_last  = 3;
        for (int i = 0; i < 3; i++) waitc[i] = 0;
        for (int it = 0; it < 50; it++) begin
            rv = 3'($urandom_range(0, 7));
            set_req(rv[0], rv[1], rv[2]);
            for (int c = 0; c < 5; c++) begin
                prev_printer = printer;
                m_next = model_next(m_state, m_last, rv);
                m_state = m_next;
                if (m_next != 0) m_last = m_next;
                tick;
                check("soak_model", printer, 2'(m_state));
                for (int r = 0; r < 3; r++) begin
                    if (rv[r] && printer != 2'(r + 1)) begin
                        if (printer != prev_printer && printer != 2'b00)
                            waitc[r]++;
                    end else begin
                        waitc[r] = 0;
                    end
                    n_cmp++;
                    assert (waitc[r] <= 2) else begin
                        n_fail++;
                        $error("FAIL soak_fairness: requester %0d waited %0d grants, limit 2", r + 1, waitc[r]);
                    end
                end
            end
            $display("soak %0d: req=%b printer=%b model=%0d", it, rv, printer, m_state);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rrarbiter.md
RRARBITER -- requirements
Module: rrarbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have no parameters; the requester count (3) and grant encoding are fixed.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 rboss  input  1  request from requester BOSS (level, held while it wants the printer).
REQ-006 reng  input  1  request from requester ENG.
REQ-007 rboy  input  1  request from requester BOY.
REQ-008 printer  output  2  registered grant: 2'b00 none, 2'b01 BOSS, 2'b10 ENG, 2'b11 BOY.
REQ-009 Port order SHALL be clk, rst, rboss, reng, rboy, printer, so positional instantiation works.

Function
REQ-010 The block SHALL be a 4-state machine, IDLE/BOSS/ENG/BOY, whose state drives printer directly in the REQ-008 encoding.
REQ-011 Requests SHALL be sampled on the rising edge of clk; the grant SHALL appear on printer at that same edge (one-cycle latency from a request change to a grant change).
REQ-012 The round-robin rotation order SHALL be BOSS -> ENG -> BOY -> BOSS.
REQ-013 Grants SHALL be non-preemptive: the current owner keeps the grant while its request stays high, regardless of other requests.
REQ-014 When the owner's request is low at a clock edge:
- the grant SHALL pass, at that same edge, to the first requester with its request high, searching in rotation order from the owner's successor;
- if no request is high, the block SHALL go to IDLE.
REQ-015 A register last SHALL hold the most recent owner and SHALL update whenever a grant is issued.
REQ-016 In IDLE, the block SHALL grant the first requester with its request high, searching in rotation order from the successor of last.
REQ-017 Handoff SHALL have no idle gap: owner release and grant to the next requester SHALL occur on the same edge.
REQ-018 If several requests rise at the same edge, exactly one grant SHALL be issued, chosen per REQ-014/REQ-016.
REQ-019 printer SHALL never take a value other than 00/01/10/11, and only one requester is granted at a time.
REQ-020 Inputs X/Z SHALL NOT be specially handled; inputs are assumed driven synchronously to clk.

Reset
REQ-021 While rst is high, state SHALL be IDLE, printer SHALL be 2'b00 and last SHALL be BOY, making BOSS first in priority after reset.
REQ-022 Assertion of rst SHALL take effect immediately (asynchronous); mid-grant reset SHALL drop the grant without waiting for a clock edge.
REQ-023 After rst deasserts, the first grant decision SHALL occur at the next rising edge of clk.

Structure
REQ-024 The state encodings (IDLE=2'b00, BOSS=2'b01, ENG=2'b10, BOY=2'b11) SHALL be defined once in the shared package rrarbiter_pkg.
REQ-025 The block SHALL be a single module with no sub-modules; next-grant selection is combinational logic in rrarbiter.

Verification
REQ-026 Reset: rst=1 with all requests high -> printer=00; first edge after release -> printer=01.
REQ-027 Single requester: reng=1 alone -> printer=10 after one edge, held while reng=1; reng=0 -> printer=00 next edge.
REQ-028 Rotation: all three requests held high, each owner drops for one cycle in turn -> grant sequence 01, 10, 11, 01.
REQ-029 Non-preemption: BOY owns, rboss rises -> printer stays 11 until rboy=0, then 01 on that edge.
REQ-030 Idle priority: last owner ENG, all requests 0 then rboss=1 and rboy=1 together -> printer=11 (BOY is after ENG).
REQ-031 Random soak: random 3-bit requests held 5 cycles each, 50 iterations:
- a scoreboard model SHALL match printer every cycle;
- no requester with its request high SHALL wait more than two other grants.
